sprite_line_fetch: RTL and testbench

SPRITE_LINE_FETCH -- requirements
Module: sprite_line_fetch

---
 rtl/final_project_pkg.sv | 17 +
 rtl/line_ram.sv | 25 ++
 rtl/sprite_line_fetch.sv | 170 +++++++++++++++++
 tb/tb_sprite_line_fetch.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/final_project_pkg.sv
// Shared fetch-state type and VGA timing constants
// for the sprite line fetcher.
package final_project_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GAP,
        DONE,
        ABORT
    } fetch_state_t;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] V_LAST   = 10'd524;

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line buffer: one write port,
// one synchronous read port.
module line_ram #(
    parameter int DEPTH = 160,
    parameter int WIDTH = 24,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/sprite_line_fetch.sv
// Double-buffered per-line image fetch from SDRAM
// with a two-cycle pixel output pipeline.
module sprite_line_fetch
    import final_project_pkg::*;
#(
    parameter logic [9:0]  X0        = 10'd240,
    parameter logic [9:0]  Y0        = 10'd180,
    parameter int          W         = 160,
    parameter int          H         = 120,
    parameter logic [25:0] BASE_ADDR = 26'h0,
    parameter logic [23:0] BG_RGB    = 24'h000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    output logic        read_req,
    output logic [25:0] address,
    input  logic        ready,
    input  logic [31:0] data,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        busy,
    output logic        underrun
);

    localparam int AW = (W > 1) ? $clog2(W) : 1;
    localparam logic [10:0] X_END = 11'(int'(X0) + W);
    localparam logic [10:0] Y_END = 11'(int'(Y0) + H);
    localparam logic [AW-1:0] I_LAST = AW'(W - 1);

    fetch_state_t state_q;
    logic [AW-1:0] i_q;
    logic [9:0]    x_prev_q;
    logic          sel_q;
    logic          fv_q;
    logic          win_q;
    logic          rsel_q;
    logic [23:0]   rdata0;
    logic [23:0]   rdata1;

    logic        trig;
    logic        swap_pt;
    logic        fetch_line;
    logic        in_win;
    logic        wr_en;
    logic [9:0]  next_y;
    logic [9:0]  line_idx;
    logic [9:0]  x_off;
    logic [25:0] line_base;
    logic        unused_bits;

    always_comb begin
        trig       = (x_pos == H_ACTIVE) && (x_prev_q != H_ACTIVE);
        swap_pt    = (x_pos == H_LAST) && (x_prev_q != H_LAST);
        next_y     = (y_pos == V_LAST) ? 10'd0 : y_pos + 10'd1;
        fetch_line = (next_y >= Y0) && ({1'b0, next_y} < Y_END);
        line_idx   = next_y - Y0;
        line_base  = BASE_ADDR + 26'(line_idx) * 26'(W);
        in_win     = (x_pos >= X0) && ({1'b0, x_pos} < X_END)
                  && (y_pos >= Y0) && ({1'b0, y_pos} < Y_END);
        x_off      = x_pos - X0;
        wr_en      = (state_q == REQ) && ready;
    end

    assign unused_bits = ^{data[31:24], x_off};

    // Bank sel_q is the front buffer; the other bank takes fetched words.
    line_ram #(.DEPTH(W), .WIDTH(24)) u_bank0 (
        .clk_i   (Clk),
        .we_i    (wr_en && sel_q),
        .waddr_i (i_q),
        .wdata_i (data[23:0]),
        .raddr_i (x_off[AW-1:0]),
        .rdata_o (rdata0)
    );

    line_ram #(.DEPTH(W), .WIDTH(24)) u_bank1 (
        .clk_i   (Clk),
        .we_i    (wr_en && !sel_q),
        .waddr_i (i_q),
        .wdata_i (data[23:0]),
        .raddr_i (x_off[AW-1:0]),
        .rdata_o (rdata1)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            i_q      <= '0;
            read_req <= 1'b0;
            address  <= '0;
            busy     <= 1'b0;
            underrun <= 1'b0;
            fv_q     <= 1'b0;
            sel_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (swap_pt) begin
                        fv_q <= 1'b0;
                    end
                    if (trig && fetch_line) begin
                        state_q  <= REQ;
                        i_q      <= '0;
                        address  <= line_base;
                        read_req <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                REQ, GAP: begin
                    if (swap_pt) begin
                        // Only a request still waiting for ready stays open.
                        underrun <= 1'b1;
                        fv_q     <= 1'b0;
                        state_q  <= ABORT;
                        read_req <= (state_q == REQ) && !ready;
                    end else if (state_q == REQ) begin
                        if (ready) begin
                            read_req <= 1'b0;
                            state_q  <= GAP;
                        end
                    end else if (i_q == I_LAST) begin
                        state_q <= DONE;
                        busy    <= 1'b0;
                    end else begin
                        i_q      <= i_q + 1'b1;
                        address  <= address + 26'd1;
                        read_req <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                DONE: begin
                    if (swap_pt) begin
                        sel_q   <= ~sel_q;
                        fv_q    <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                ABORT: begin
                    if (!read_req || ready) begin
                        read_req <= 1'b0;
                        busy     <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_prev_q <= '0;
            win_q    <= 1'b0;
            rsel_q   <= 1'b0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else begin
            x_prev_q <= x_pos;
            win_q    <= fv_q && in_win;
            rsel_q   <= sel_q;
            {red, green, blue} <= win_q ? (rsel_q ? rdata1 : rdata0)
                                        : BG_RGB;
        end
    end

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Directed/randomized bench for sprite_line_fetch with a
// line-level pixel model and an SDRAM responder.
module tb_sprite_line_fetch;

    localparam logic [9:0]  X0     = 10'd240;
    localparam logic [9:0]  Y0     = 10'd180;
    localparam int          W      = 160;
    localparam int          H      = 120;
    localparam logic [25:0] BASE   = 26'h0;
    localparam logic [25:0] BASE_B = 26'h3FFFFF0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  x_pos = '0;
    logic [9:0]  y_pos = '0;
    logic        read_req;
    logic [25:0] address;
    logic        ready = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  red, green, blue;
    logic        busy, underrun;

    logic [9:0]  x_b = '0;
    logic [9:0]  y_b = '0;
    logic        read_req_b;
    logic [25:0] address_b;
    logic        ready_b = 1'b0;
    logic [31:0] data_b = '0;
    logic [7:0]  red_b, green_b, blue_b;
    logic        busy_b, underrun_b;

    int n_chk = 0;
    int n_fail = 0;
    int lat = 3;
    logic [23:0] salt = '0;
    logic [25:0] addrq[$];

    bit          mv = 1'b0;
    int          mline = 0;
    logic [23:0] msalt = '0;

    always #10 clk = ~clk;

    sprite_line_fetch dut (
        .Clk(clk), .Reset(rst), .x_pos(x_pos), .y_pos(y_pos),
        .read_req(read_req), .address(address), .ready(ready),
        .data(data), .red(red), .green(green), .blue(blue),
        .busy(busy), .underrun(underrun)
    );

    sprite_line_fetch #(.Y0(10'd0), .BASE_ADDR(BASE_B)) dut_b (
        .Clk(clk), .Reset(rst), .x_pos(x_b), .y_pos(y_b),
        .read_req(read_req_b), .address(address_b), .ready(ready_b),
        .data(data_b), .red(red_b), .green(green_b), .blue(blue_b),
        .busy(busy_b), .underrun(underrun_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Image line l word c lives at BASE + l*W + c; pixel = low 24 bits ^ salt.
    function automatic logic [23:0] exp_pix(input logic [9:0] x,
                                            input logic [9:0] y);
        int col;
        col = int'(x) - int'(X0);
        if (mv && col >= 0 && col < W &&
            int'(y) >= int'(Y0) && int'(y) < int'(Y0) + H)
            return 24'(int'(BASE) + mline * W + col) ^ msalt;
        return 24'h000000;
    endfunction

    initial begin : responder
        bit pend;
        int cnt;
        logic [25:0] ra;
        pend = 1'b0;
        cnt = 0;
        ra = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                ready = 1'b0;
            end else if (ready) begin
                ready = 1'b0;
                pend = 1'b0;
                chk("req_gap", 32'(read_req), 0);
            end else if (pend) begin
                chk("addr_stable", 32'(address), 32'(ra));
                if (cnt == 0) begin
                    ready = 1'b1;
                    data = {8'($urandom), 24'(ra) ^ salt};
                end else begin
                    cnt--;
                end
            end else if (read_req) begin
                pend = 1'b1;
                cnt = lat;
                ra = address;
                addrq.push_back(address);
            end
        end
    end

    task automatic wait_busy_low(input int budget);
        int k;
        k = 0;
        while (busy === 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk("busy_drop", 32'(busy), 0);
    endtask

    task automatic do_line(input logic [9:0] y, input int l,
                           input logic [23:0] s);
        int ln;
        ln = int'(y) + 1 - int'(Y0);
        lat = l;
        salt = s;
        addrq.delete();
        y_pos = y;
        x_pos = 10'd640;
        step();
        chk("busy_start", 32'(busy), 1);
        x_pos = 10'd700;
        wait_busy_low(8000);
        chk("n_req", addrq.size(), W);
        for (int k = 0; k < W && k < addrq.size(); k++)
            chk("addr", 32'(addrq[k]), int'(BASE) + ln * W + k);
        x_pos = 10'd799;
        step();
        chk("swap_busy", 32'(busy), 0);
        x_pos = 10'd0;
        step();
        mv = 1'b1;
        mline = ln;
        msalt = s;
    endtask

    task automatic stream(input logic [9:0] y, input int n);
        logic [23:0] q[$];
        y_pos = y;
        for (int k = 0; k < n + 2; k++) begin
            if (q.size() == 2)
                chk("pix_stream", {red, green, blue}, q.pop_front());
            x_pos = 10'($urandom_range(230, 410));
            q.push_back(exp_pix(x_pos, y));
            step();
        end
    endtask

    task automatic edge_px(input logic [9:0] y);
        logic [9:0] xs[4];
        xs = '{10'd239, 10'd240, 10'd399, 10'd400};
        y_pos = y;
        for (int k = 0; k < 4; k++) begin
            x_pos = xs[k];
            step();
            step();
            chk("pix_edge", {red, green, blue}, exp_pix(xs[k], y));
        end
    endtask

    initial begin : main
        int k;
        int n_before;
        logic [9:0] yr;

        rst = 1'b1;
        step();
        step();
        chk("rst_req", 32'(read_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_addr", 32'(address), 0);
        chk("rst_rgb", {red, green, blue}, 0);
        rst = 1'b0;
        step();

        do_line(10'd179, 3, 24'h0);
        y_pos = 10'd180;
        x_pos = 10'd245;
        step();
        step();
        chk("pix_245", {red, green, blue}, 24'h000005);
        x_pos = 10'd239;
        step();
        step();
        chk("pix_239", {red, green, blue}, 24'h000000);
        x_pos = 10'd400;
        step();
        step();
        chk("pix_400", {red, green, blue}, 24'h000000);
        stream(10'd180, 40);
        stream(10'd179, 10);

        addrq.delete();
        y_pos = 10'd299;
        x_pos = 10'd640;
        step();
        x_pos = 10'd700;
        repeat (5) step();
        chk("oow_req", 32'(read_req), 0);
        chk("oow_busy", 32'(busy), 0);
        chk("oow_nreq", addrq.size(), 0);
        x_pos = 10'd799;
        step();
        mv = 1'b0;
        x_pos = 10'd0;
        step();
        stream(10'd180, 20);

        do_line(10'd250, 1, 24'($urandom));
        chk("addr_11360", 32'(addrq.size() > 0 ? addrq[0] : 26'h0), 11360);
        stream(10'd251, 40);
        edge_px(10'd251);

        do_line(10'd298, 0, 24'($urandom));
        stream(10'd299, 20);
        stream(10'd300, 10);

        for (int r = 0; r < 3; r++) begin
            yr = 10'($urandom_range(179, 297));
            do_line(yr, $urandom_range(0, 4), 24'($urandom));
            stream(yr + 10'd1, 30);
            edge_px(yr + 10'd1);
        end

        addrq.delete();
        lat = 20;
        salt = 24'($urandom);
        y_pos = 10'd180;
        x_pos = 10'd640;
        step();
        x_pos = 10'd700;
        repeat (30) step();
        chk("busy_pre_abort", 32'(busy), 1);
        x_pos = 10'd799;
        step();
        chk("underrun_set", 32'(underrun), 1);
        chk("busy_abort", 32'(busy), 1);
        y_pos = 10'd181;
        x_pos = 10'd640;
        step();
        x_pos = 10'd700;
        k = 0;
        while (read_req === 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk("abort_release", 32'(read_req), 0);
        n_before = addrq.size();
        repeat (10) step();
        chk("abort_idle_req", 32'(read_req), 0);
        chk("abort_idle_busy", 32'(busy), 0);
        chk("abort_no_new_req", addrq.size(), n_before);
        chk("underrun_sticky", 32'(underrun), 1);
        mv = 1'b0;
        stream(10'd181, 20);

        do_line(10'd200, 2, 24'($urandom));
        addrq.delete();
        lat = 3;
        y_pos = 10'd201;
        x_pos = 10'd640;
        step();
        x_pos = 10'd250;
        k = 0;
        while (addrq.size() < 58 && k < 2000) begin
            step();
            k++;
        end
        chk("i57_reached", addrq.size(), 58);
        chk("i57_addr", 32'(address), 22 * W + 57);
        chk("pix_pre_rst", {red, green, blue}, exp_pix(10'd250, 10'd201));
        chk("underrun_pre_rst", 32'(underrun), 1);
        rst = 1'b1;
        #1;
        chk("rst_async_req", 32'(read_req), 0);
        chk("rst_async_busy", 32'(busy), 0);
        chk("rst_async_rgb", {red, green, blue}, 0);
        chk("rst_async_underrun", 32'(underrun), 0);
        chk("rst_async_addr", 32'(address), 0);
        step();
        rst = 1'b0;
        mv = 1'b0;
        step();
        do_line(10'd201, 3, 24'($urandom));
        stream(10'd202, 30);

        y_b = 10'd524;
        x_b = 10'd640;
        step();
        x_b = 10'd700;
        for (int j = 0; j < 20; j++) begin
            k = 0;
            while (read_req_b !== 1'b1 && k < 10) begin
                step();
                k++;
            end
            chk("wrap_req", 32'(read_req_b), 1);
            chk("wrap_addr", 32'(address_b),
                (int'(BASE_B) + j) % (1 << 26));
            ready_b = 1'b1;
            data_b = 32'($urandom);
            step();
            ready_b = 1'b0;
            chk("wrap_gap", 32'(read_req_b), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
